// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int STALL_W = 16;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with increment enable; cleared by the async reset.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, halt drain,
// data-memory wait with timeout, and a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal issue; hazard, branch and HLT handling
// MEM_WAIT | data access outstanding, pipeline frozen
// DRAIN    | HLT left ID, older instructions retiring
// HALTED   | core stopped; only reset leaves
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hz_stall,
  input  logic               br_taken,
  input  logic               halt_id,
  input  logic               dmem_req,
  input  logic               dmem_ack,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               idex_we,
  output logic               exmem_we,
  output logic               memwb_we,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               halted,
  output logic               mem_err,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);
  localparam logic [7:0] DRAIN_V   = 8'(DRAIN_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic [7:0] drain_cnt, drain_nx;
  logic       err_nx;
  logic       mem_pend;
  logic       run_rules;
  logic       frz;
  logic       pc_c, ifid_c, idex_c, exmem_c, memwb_c, ifid_fl_c, idex_fl_c;

  assign mem_pend = dmem_req && !dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      drain_cnt <= 8'd0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      drain_cnt <= drain_nx;
      mem_err   <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wait_nx   = 8'd0;
    drain_nx  = drain_cnt;
    err_nx    = mem_err;
    run_rules = 1'b0;
    frz       = 1'b0;
    pc_c      = 1'b1;
    ifid_c    = 1'b1;
    idex_c    = 1'b1;
    exmem_c   = 1'b1;
    memwb_c   = 1'b1;
    ifid_fl_c = 1'b0;
    idex_fl_c = 1'b0;

    case (state)
      RUN: run_rules = 1'b1;
      MEM_WAIT: begin
        if (mem_pend) begin
          frz = 1'b1;
          if (wait_cnt == TIMEOUT_V) begin
            state_nx = HALTED;
            err_nx   = 1'b1;
          end else begin
            wait_nx = wait_cnt + 8'd1;
          end
        end else begin
          run_rules = 1'b1;
        end
      end
      DRAIN: begin
        pc_c      = 1'b0;
        ifid_fl_c = 1'b1;
        // Drain shares the wait counter so a stuck access still times out.
        if (mem_pend) begin
          frz = 1'b1;
          if (wait_cnt == TIMEOUT_V) begin
            state_nx = HALTED;
            err_nx   = 1'b1;
          end else begin
            wait_nx = wait_cnt + 8'd1;
          end
        end else if (drain_cnt == 8'd0) begin
          state_nx = HALTED;
        end else begin
          drain_nx = drain_cnt - 8'd1;
        end
      end
      default: frz = 1'b1;
    endcase

    if (run_rules) begin
      state_nx = RUN;
      if (mem_pend) begin
        frz      = 1'b1;
        state_nx = MEM_WAIT;
        wait_nx  = 8'd1;
      end else if (hz_stall) begin
        pc_c      = 1'b0;
        ifid_c    = 1'b0;
        idex_fl_c = 1'b1;
      end else if (br_taken) begin
        ifid_fl_c = 1'b1;
      end else if (halt_id) begin
        pc_c      = 1'b0;
        ifid_fl_c = 1'b1;
        state_nx  = DRAIN;
        drain_nx  = DRAIN_V;
      end
    end
  end

  always_comb begin
    if (frz || !rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
      memwb_we   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end else begin
      pc_we      = pc_c;
      ifid_we    = ifid_c;
      idex_we    = idex_c;
      exmem_we   = exmem_c;
      memwb_we   = memwb_c;
      ifid_flush = ifid_fl_c;
      idex_flush = idex_fl_c;
    end
  end

  assign halted = (state == HALTED);

  sat_cnt #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (((state == RUN) || (state == MEM_WAIT)) && !pc_we),
    .cnt   (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expected values.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hz_stall, br_taken, halt_id, dmem_req, dmem_ack;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, halted, mem_err;
  logic [15:0] stall_cycles;
  logic [4:0]  en;
  logic [1:0]  fl;
  int          checks = 0;
  int          failures = 0;

  assign en = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
  assign fl = {ifid_flush, idex_flush};

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .br_taken(br_taken),
    .halt_id(halt_id), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  task automatic drive(input logic hz, input logic br, input logic hl,
                       input logic rq, input logic ak);
    hz_stall = hz; br_taken = br; halt_id = hl; dmem_req = rq; dmem_ack = ak;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    checks++;
    if (en !== 5'b00000 || fl !== 2'b00 || halted !== 1'b0 || mem_err !== 1'b0 || stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold: en=%b fl=%b halted=%b err=%b stall=%0d want en=00000 fl=00 0 0 0", en, fl, halted, mem_err, stall_cycles);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (en !== 5'b11111 || fl !== 2'b00 || stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_release: en=%b fl=%b stall=%0d want en=11111 fl=00 stall=0", en, fl, stall_cycles);
    end
  endtask

  task automatic test_hz_stall();
    do_reset();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (en !== 5'b00111 || fl !== 2'b01) begin
      failures++;
      $display("FAIL hz_stall: en=%b fl=%b want en=00111 fl=01", en, fl);
    end
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'd1 || en !== 5'b11111) begin
      failures++;
      $display("FAIL hz_stall_count: stall=%0d en=%b want stall=1 en=11111", stall_cycles, en);
    end
    step();
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (en !== 5'b00111 || fl !== 2'b01) begin
      failures++;
      $display("FAIL stall_over_branch: en=%b fl=%b want en=00111 fl=01", en, fl);
    end
    step();
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (en !== 5'b11111 || fl !== 2'b10) begin
      failures++;
      $display("FAIL branch_only: en=%b fl=%b want en=11111 fl=10", en, fl);
    end
    step();
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    checks++;
    if (en !== 5'b11111 || fl !== 2'b00) begin
      failures++;
      $display("FAIL single_cycle_mem: en=%b fl=%b want en=11111 fl=00", en, fl);
    end
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'd1) begin
      failures++;
      $display("FAIL priority_count: stall=%0d want 1", stall_cycles);
    end
  endtask

  task automatic test_mem_ack3();
    do_reset();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (en !== 5'b00000 || fl !== 2'b00) begin
        failures++;
        $display("FAIL mem_freeze_c%0d: en=%b fl=%b want en=00000 fl=00", i + 1, en, fl);
      end
      step();
    end
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    checks++;
    if (en !== 5'b11111) begin
      failures++;
      $display("FAIL mem_ack_c3: en=%b want 11111", en);
    end
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'd2 || halted !== 1'b0 || mem_err !== 1'b0 || en !== 5'b11111) begin
      failures++;
      $display("FAIL mem_ack3_after: stall=%0d halted=%b err=%b en=%b want 2 0 0 11111", stall_cycles, halted, mem_err, en);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 0, 0, 1, 0);
    // request cycle in RUN plus wait cycles 1..15 in MEM_WAIT
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (en !== 5'b00000 || halted !== 1'b0 || mem_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait_c%0d: en=%b halted=%b err=%b want 00000 0 0", i, en, halted, mem_err);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || mem_err !== 1'b1 || en !== 5'b00000 || fl !== 2'b00) begin
      failures++;
      $display("FAIL timeout_halt: halted=%b err=%b en=%b fl=%b want 1 1 00000 00", halted, mem_err, en, fl);
    end
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || mem_err !== 1'b1 || en !== 5'b00000 || stall_cycles !== 16'd16) begin
      failures++;
      $display("FAIL timeout_sticky: halted=%b err=%b en=%b stall=%0d want 1 1 00000 16", halted, mem_err, en, stall_cycles);
    end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) step();
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    checks++;
    if (en !== 5'b11111) begin
      failures++;
      $display("FAIL ack_at_limit: en=%b want 11111", en);
    end
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || mem_err !== 1'b0 || en !== 5'b11111 || stall_cycles !== 16'd15) begin
      failures++;
      $display("FAIL ack_at_limit_after: halted=%b err=%b en=%b stall=%0d want 0 0 11111 15", halted, mem_err, en, stall_cycles);
    end
  endtask

  task automatic test_drain();
    logic [4:0] exp_en [1:5];
    logic [1:0] exp_fl [1:5];
    exp_en = '{5'b01111, 5'b00000, 5'b01111, 5'b01111, 5'b01111};
    exp_fl = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b10};
    do_reset();
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (en !== 5'b01111 || fl !== 2'b10) begin
      failures++;
      $display("FAIL drain_hlt: en=%b fl=%b want 01111 10", en, fl);
    end
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) drive(1, 0, 0, 0, 0);
      else if (c == 2) drive(0, 0, 0, 1, 0);
      else drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (en !== exp_en[c] || fl !== exp_fl[c] || halted !== 1'b0) begin
        failures++;
        $display("FAIL drain_c%0d: en=%b fl=%b halted=%b want %b %b 0", c, en, fl, halted, exp_en[c], exp_fl[c]);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || mem_err !== 1'b0 || en !== 5'b00000 || stall_cycles !== 16'd1) begin
      failures++;
      $display("FAIL drain_halted: halted=%b err=%b en=%b stall=%0d want 1 0 00000 1", halted, mem_err, en, stall_cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(0, 0, 0, 1, 0);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 5'b00000 || stall_cycles !== 16'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait: en=%b stall=%0d halted=%b want 00000 0 0", en, stall_cycles, halted);
    end
    drive(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (en !== 5'b11111 || stall_cycles !== 16'd0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait_release: en=%b stall=%0d err=%b want 11111 0 0", en, stall_cycles, mem_err);
    end
    // the wait counter must have cleared: a fresh request then ack on cycle 2
    step();
    drive(0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    checks++;
    if (en !== 5'b11111) begin
      failures++;
      $display("FAIL reset_mid_wait_reuse: en=%b want 11111", en);
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_hz_stall();
    test_priority();
    test_mem_ack3();
    test_timeout();
    test_ack_at_limit();
    test_drain();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
